// File: rtl/mul_acc_stage_if.sv
// Handshake bundle between the multiplier-facing driver and the accumulate stage.
// The producer/consumer side uses the master modport; the stage itself uses slave.
interface mul_acc_stage_if #(
    parameter int ACC_W = 24,
    parameter int LEN_W = 4
);
    logic             start;
    logic [LEN_W-1:0] len;
    logic             Signed;
    logic [15:0]      Prod;
    logic             prod_valid;
    logic             prod_ready;
    logic [ACC_W-1:0] acc_out;
    logic             overflow;
    logic             out_valid;
    logic             out_ready;
    logic             busy;

    modport master (
        output start, len, Signed, Prod, prod_valid, out_ready,
        input  prod_ready, acc_out, overflow, out_valid, busy
    );

    modport slave (
        input  start, len, Signed, Prod, prod_valid, out_ready,
        output prod_ready, acc_out, overflow, out_valid, busy
    );
endinterface

// File: rtl/mul_acc_stage.sv
// Saturating dot-product accumulator fed by the 16-bit multiplier output.
// It sums a programmed number of products and hands back the result over a valid/ready port.
module mul_acc_stage #(
    parameter int ACC_W = 24,
    parameter int LEN_W = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    mul_acc_stage_if.slave bus
);
    localparam int SUM_W = ACC_W + 2;
    localparam logic [ACC_W-1:0] SMAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] SMIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [ACC_W-1:0] UMAX = {ACC_W{1'b1}};

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    state_t           state;
    state_t           state_next;
    logic [LEN_W-1:0] cnt;
    logic             mode;
    logic             xfer;
    logic [SUM_W-1:0] ext;
    logic [SUM_W-1:0] acc_x;
    logic [SUM_W-1:0] sum;
    logic [ACC_W-1:0] sum_clamped;
    logic             clamp_hit;

    // prod_ready is registered and high exactly while in ACC, so it doubles as the state qualifier
    assign xfer = bus.prod_valid && bus.prod_ready;

    // Two guard bits give headroom, so an out-of-range sum is detected before any wrap
    always_comb begin
        ext         = mode ? {{(SUM_W-16){bus.Prod[15]}}, bus.Prod}
                           : {{(SUM_W-16){1'b0}}, bus.Prod};
        acc_x       = mode ? {{2{bus.acc_out[ACC_W-1]}}, bus.acc_out}
                           : {2'b00, bus.acc_out};
        sum         = acc_x + ext;
        sum_clamped = sum[ACC_W-1:0];
        clamp_hit   = 1'b0;
        if (mode) begin
            if (sum[SUM_W-1:ACC_W-1] != 3'b000 && sum[SUM_W-1:ACC_W-1] != 3'b111) begin
                clamp_hit   = 1'b1;
                sum_clamped = sum[SUM_W-1] ? SMIN : SMAX;
            end
        end else if (sum[SUM_W-1:ACC_W] != 2'b00) begin
            clamp_hit   = 1'b1;
            sum_clamped = UMAX;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = (bus.len == '0) ? DONE : ACC;
                end
            end
            ACC: begin
                if (cnt == '0 || (xfer && cnt == LEN_W'(1))) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs are registered from the next state so they change together with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            mode           <= 1'b0;
            bus.acc_out    <= '0;
            bus.overflow   <= 1'b0;
            bus.out_valid  <= 1'b0;
            bus.prod_ready <= 1'b0;
            bus.busy       <= 1'b0;
        end else begin
            state          <= state_next;
            bus.prod_ready <= (state_next == ACC);
            bus.out_valid  <= (state_next == DONE);
            bus.busy       <= (state_next != IDLE);
            if (state == IDLE && bus.start) begin
                bus.acc_out  <= '0;
                bus.overflow <= 1'b0;
                mode         <= bus.Signed;
                cnt          <= bus.len;
            end else if (state == ACC && xfer) begin
                bus.acc_out  <= sum_clamped;
                bus.overflow <= bus.overflow | clamp_hit;
                if (cnt != '0) begin
                    cnt <= cnt - LEN_W'(1);
                end
            end
        end
    end
endmodule
